// File: rtl/sram_arbiter.sv
// sram_arbiter: time-shares one SRAM controller between pixel writer (A) and pixel reader (B).
// Define SRAM_ARB_TIMEOUT_EN to enable the drain watchdog.
module sram_arbiter #(
    parameter int unsigned QUANTUM        = 64,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    input  logic sram_start,
    input  logic sram_ready,
    output logic select,
    output logic grant_a,
    output logic grant_b,
    output logic busy,
    output logic err_timeout
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, DRAIN} state_t;
    state_t           state_q, state_d;
    logic             select_q, select_d;
    logic             grant_a_q, grant_b_q;
    logic             busy_q, busy_d;
    logic             pre_b_q, pre_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
    logic             own_req, oth_req, preempt, to_fire;
    assign cnt_sat = &cnt_q ? cnt_q : cnt_q + CNT_W'(sram_start);
    assign own_req = state_q == OWN_A ? req_a : req_b;
    assign oth_req = state_q == OWN_A ? req_b : req_a;
    assign preempt = QUANTUM != 0 && 32'(cnt_sat) >= QUANTUM && oth_req;
`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] dc_q, dc_d;
    logic            err_q;
    assign dc_d    = state_q != DRAIN ? '0 : busy_q ? dc_q + TO_W'(1) : dc_q;
    assign to_fire = state_q == DRAIN && busy_q && 32'(dc_q) == TIMEOUT_CYCLES - 1;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            dc_q  <= dc_d;
            err_q <= err_q | to_fire;
        end
    end
    assign err_timeout = err_q;
`else
    assign to_fire     = 1'b0;
    assign err_timeout = 1'b0 && TIMEOUT_CYCLES != 0;
`endif
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        pre_b_d  = pre_b_q;
        cnt_d    = cnt_q;
        busy_d   = sram_start ? 1'b1 : sram_ready ? 1'b0 : busy_q;
        unique case (state_q)
            IDLE: begin
                // a preempted reader yields the next arbitration to a waiting writer
                if (req_b && !(pre_b_q && req_a)) begin
                    state_d  = OWN_B;
                    select_d = 1'b1;
                end else if (req_a) begin
                    state_d  = OWN_A;
                    select_d = 1'b0;
                end
                if (state_d != IDLE) begin
                    pre_b_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            OWN_A, OWN_B: begin
                cnt_d = cnt_sat;
                if (!own_req || preempt) state_d = DRAIN;
                if (state_q == OWN_B && own_req && preempt) pre_b_d = 1'b1;
            end
            default: begin
                if (to_fire) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (!busy_q && !sram_start) begin
                    state_d = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            select_q  <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            busy_q    <= 1'b0;
            pre_b_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            select_q  <= select_d;
            grant_a_q <= state_d == OWN_A;
            grant_b_q <= state_d == OWN_B;
            busy_q    <= busy_d;
            pre_b_q   <= pre_b_d;
            cnt_q     <= cnt_d;
        end
    end
    assign select  = select_q;
    assign grant_a = grant_a_q;
    assign grant_b = grant_b_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic against an in-bench reference model.
module tb_sram_arbiter;
    localparam int Q  = 4;
    localparam int TO = 16;
`ifdef SRAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic clk = 0, reset_n = 0, req_a = 0, req_b = 0, sram_start = 0, sram_ready = 0;
    logic select, grant_a, grant_b, busy, err_timeout;
    int   n_chk = 0, n_fail = 0;

    sram_arbiter #(.QUANTUM(Q), .CNT_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_a(req_a), .req_b(req_b),
        .sram_start(sram_start), .sram_ready(sram_ready), .select(select),
        .grant_a(grant_a), .grant_b(grant_b), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // owner: 0 none, 1 writer, 2 reader; draining marks the hand-over gap
    int owner = 0, starts = 0, drain_wait = 0;
    bit draining = 0, m_sel = 0, m_busy = 0, m_err = 0, a_first = 0, started = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit nb, mine, other;
        started = 1;
        if (!reset_n) begin
            owner = 0; starts = 0; drain_wait = 0;
            draining = 0; m_sel = 0; m_busy = 0; m_err = 0; a_first = 0;
            return;
        end
        nb = sram_start || (m_busy && !sram_ready);
        if (draining) begin
            if (m_busy) drain_wait++;
            if (TO_EN && m_busy && drain_wait == TO) begin
                nb = 0; m_err = 1; draining = 0;
            end else if (!m_busy && !sram_start) begin
                draining = 0;
            end
            if (!draining) drain_wait = 0;
        end else if (owner == 0) begin
            if (req_b && !(a_first && req_a)) begin
                owner = 2; m_sel = 1; a_first = 0; starts = 0;
            end else if (req_a) begin
                owner = 1; m_sel = 0; a_first = 0; starts = 0;
            end
        end else begin
            mine  = owner == 1 ? req_a : req_b;
            other = owner == 1 ? req_b : req_a;
            if (sram_start && starts < 255) starts++;
            if (!mine || (starts >= Q && other)) begin
                if (owner == 2 && mine) a_first = 1;
                owner = 0; draining = 1;
            end
        end
        m_busy = nb;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("m_select", select, m_sel);
            chk("m_grant_a", grant_a, owner == 1 && !draining);
            chk("m_grant_b", grant_b, owner == 2 && !draining);
            chk("m_busy", busy, m_busy);
            chk("m_err", err_timeout, m_err);
            chk("one_grant", grant_a & grant_b, 1'b0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic stream(input bit on_b, input string tag);
        for (int i = 1; i <= Q; i++) begin
            sram_start = 1; sram_ready = i > 1;
            tick();
            chk(tag, on_b ? grant_b : grant_a, i < Q);
        end
        sram_start = 0; sram_ready = 1;
        tick();
        sram_ready = 0;
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int ta = 0, tb = 0, pend = 0;
        // reset with both requesting
        req_a = 1; req_b = 1;
        repeat (3) begin
            tick();
            chk("rst_sel", select, 0); chk("rst_ga", grant_a, 0);
            chk("rst_gb", grant_b, 0); chk("rst_busy", busy, 0);
        end
        reset_n = 1;
        tick();
        chk("first_gb", grant_b, 1); chk("first_sel", select, 1); chk("first_ga", grant_a, 0);
        // reader bursts then releases, writer follows two cycles later
        repeat (3) begin
            sram_start = 1; tick(); sram_start = 0;
            chk("b_busy", busy, 1);
            sram_ready = 1; tick(); sram_ready = 0;
        end
        chk("b_hold", grant_b, 1);
        req_b = 0;
        tick(); chk("rel_gb", grant_b, 0); chk("rel_sel", select, 1);
        tick(); chk("idle_ga", grant_a, 0);
        tick(); chk("hand_ga", grant_a, 1); chk("hand_sel", select, 0);
        // writer releases with a transaction outstanding
        sram_start = 1; tick(); sram_start = 0;
        req_a = 0; req_b = 1;
        tick(); chk("drain_ga", grant_a, 0); chk("drain_busy", busy, 1);
        repeat (9) begin
            tick(); chk("drain_sel", select, 0); chk("drain_gb", grant_b, 0);
        end
        sram_ready = 1; tick(); sram_ready = 0;
        chk("drain_done", busy, 0); chk("drain_sel2", select, 0);
        tick(); chk("drain_idle_sel", select, 0); chk("drain_idle_gb", grant_b, 0);
        tick(); chk("drain_gb1", grant_b, 1); chk("drain_sel1", select, 1);
        // preemption and counter restart
        req_b = 0; req_a = 1;
        tick(); tick(); tick(); chk("a_own", grant_a, 1);
        req_b = 1;
        stream(0, "preempt_a");
        tick(); tick(); chk("after_pa_gb", grant_b, 1); chk("after_pa_sel", select, 1);
        req_b = 0;
        tick(); tick(); tick(); chk("regrant_a", grant_a, 1);
        req_b = 1;
        stream(0, "quantum_restart");
        tick(); tick(); chk("b_again", grant_b, 1);
        stream(1, "preempt_b");
        tick(); tick(); chk("fair_ga", grant_a, 1); chk("fair_gb", grant_b, 0);
        // start and ready coincide while the writer releases
        sram_start = 1; tick(); chk("co_busy0", busy, 1);
        sram_ready = 1; req_a = 0;
        tick(); sram_start = 0; sram_ready = 0;
        chk("co_busy", busy, 1); chk("co_ga", grant_a, 0);
        repeat (3) begin
            tick(); chk("co_hold", busy, 1); chk("co_gb", grant_b, 0);
        end
        sram_ready = 1; tick(); sram_ready = 0; chk("co_clear", busy, 0);
        tick(); tick(); chk("co_gb1", grant_b, 1);
        // no completion after release: watchdog or indefinite drain
        sram_start = 1; req_b = 0;
        tick(); sram_start = 0;
        chk("to_busy0", busy, 1); chk("to_gb", grant_b, 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("to_busy", busy, TO_EN ? k < TO : 1'b1);
            chk("to_err", err_timeout, TO_EN ? k >= TO : 1'b0);
        end
        chk("to_sel", select, 1);
        sram_ready = 1; tick(); sram_ready = 0;
        tick(); tick(); chk("to_recover", busy, 0); chk("to_ga", grant_a, 0);
        // randomized traffic
        reset_n = 0; req_a = 0; req_b = 0;
        tick(); tick();
        reset_n = 1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            tick();
            if (ta == 0) begin
                req_a = !req_a; ta = req_a ? $urandom_range(1, 40) : $urandom_range(0, 12);
            end else ta--;
            if (tb == 0) begin
                req_b = !req_b; tb = req_b ? $urandom_range(1, 40) : $urandom_range(0, 12);
            end else tb--;
            reset_n = $urandom_range(0, 599) != 0;
            if (!reset_n) begin
                pend = 0; sram_start = 0; sram_ready = 0;
            end else begin
                sram_ready = pend == 1;
                if (pend > 0) pend--;
                sram_start = pend == 0 && ((grant_a && req_a) || (grant_b && req_b))
                             && $urandom_range(0, 3) != 0;
                if (sram_start)
                    pend = $urandom_range(0, 15) == 0 ? $urandom_range(18, 30) : $urandom_range(1, 6);
            end
        end
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
